// File: rtl/multi_debouncer.sv
// N-channel button conditioner: 2-flop synchroniser, tick-gated debounce,
// press/release/long-press pulses and a clearable press counter per channel.
module multi_debouncer #(
  parameter int N_CHANNELS       = 4,
  parameter int COUNTER_BITS     = 4,
  parameter int TICK_DIV         = 10,
  parameter int LONG_PRESS_TICKS = 64,
  parameter int COUNT_WIDTH      = 8
) (
  input  logic                              clk_100mhz,
  input  logic                              rst,
  input  logic [N_CHANNELS-1:0]             btn_raw,
  input  logic [N_CHANNELS-1:0]             count_clear,
  output logic [N_CHANNELS-1:0]             btn_clean,
  output logic [N_CHANNELS-1:0]             press_pulse,
  output logic [N_CHANNELS-1:0]             release_pulse,
  output logic [N_CHANNELS-1:0]             long_press,
  output logic [N_CHANNELS*COUNT_WIDTH-1:0] press_count
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_TICKS - 1);

  logic [DIV_W-1:0]      div;
  logic                  tick;
  logic [N_CHANNELS-1:0] sync_meta;
  logic [N_CHANNELS-1:0] btn_sync;

  // Shared clock enable replacing the old derived 10 MHz clock.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst)                div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else                    div <= div + 1'b1;
  end

  assign tick = (div == DIV_LAST);

  // NOTE: non-blocking assignments make both stages sample the pre-edge
  // values; blocking here would collapse the synchroniser into one flop.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      btn_sync  <= '0;
    end else begin
      sync_meta <= btn_raw;
      btn_sync  <= sync_meta;
    end
  end

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    logic [COUNTER_BITS-1:0] db_cnt;
    logic                    clean_q;
    logic                    clean_prev;
    logic                    press_q;
    logic                    release_q;
    logic [HOLD_W-1:0]       hold_cnt;
    logic                    long_q;
    logic [COUNT_WIDTH-1:0]  count_q;

    // The window only advances on ticks; any agreeing tick restarts it.
    always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
        db_cnt  <= '0;
        clean_q <= 1'b0;
      end else if (tick) begin
        if (btn_sync[i] == clean_q) begin
          db_cnt <= '0;
        end else if (&db_cnt) begin
          clean_q <= ~clean_q;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
        clean_prev <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
      end else begin
        clean_prev <= clean_q;
        press_q    <= clean_q & ~clean_prev;
        release_q  <= ~clean_q & clean_prev;
      end
    end

    // Hold counter saturates so long_press fires exactly once per press.
    always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
        hold_cnt <= '0;
        long_q   <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (!clean_q) begin
          hold_cnt <= '0;
        end else if (tick && hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
          long_q   <= (hold_cnt == HOLD_FIRE);
        end
      end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst)                 count_q <= '0;
      else if (count_clear[i]) count_q <= '0;
      else if (press_q)        count_q <= count_q + 1'b1;
    end

    assign btn_clean[i]                               = clean_q;
    assign press_pulse[i]                             = press_q;
    assign release_pulse[i]                           = release_q;
    assign long_press[i]                              = long_q;
    assign press_count[i*COUNT_WIDTH +: COUNT_WIDTH]  = count_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed + randomized bench for multi_debouncer, checked every cycle against
// a tick/run-length reference model.
module tb_multi_debouncer;

  localparam int N   = 4;
  localparam int CB  = 4;
  localparam int TD  = 10;
  localparam int LP  = 64;
  localparam int CW  = 3;
  localparam int WIN = 1 << CB;

  logic              clk_100mhz = 1'b0;
  logic              rst        = 1'b1;
  logic [N-1:0]      btn_raw    = '0;
  logic [N-1:0]      count_clear = '0;
  logic [N-1:0]      btn_clean, press_pulse, release_pulse, long_press;
  logic [N*CW-1:0]   press_count;

  multi_debouncer #(
    .N_CHANNELS(N), .COUNTER_BITS(CB), .TICK_DIV(TD),
    .LONG_PRESS_TICKS(LP), .COUNT_WIDTH(CW)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .count_clear  (count_clear),
    .btn_clean    (btn_clean),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .press_count  (press_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int passed = 0;
  int total  = 0;

  // Reference model state: edges since reset, and per channel the synchroniser
  // view, mismatch run length in ticks, ticks held, and the press counter.
  int n_edges;
  bit m_s1[N], m_s2[N], m_clean[N], m_prev[N], m_press[N], m_rel[N], m_long[N];
  int m_run[N], m_hold[N], m_cnt[N];

  logic [N-1:0] clear_on_press = '0;
  logic [N-1:0] manual_clear   = '0;
  int press_seen[N], release_seen[N], long_seen[N];
  int cyc;
  int rise_at[N], long_at[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    n_edges = 0;
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_clean[i] = 0; m_prev[i] = 0;
      m_press[i] = 0; m_rel[i] = 0; m_long[i] = 0;
      m_run[i] = 0; m_hold[i] = 0; m_cnt[i] = 0;
    end
  endtask

  function automatic logic [N-1:0] exp_press();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_press[i];
    return v;
  endfunction

  task automatic model_edge(input logic [N-1:0] raw, input logic [N-1:0] clr);
    bit tick;
    tick = (n_edges % TD) == TD - 1;
    for (int i = 0; i < N; i++) begin
      bit c_old;
      c_old = m_clean[i];
      if (clr[i])          m_cnt[i] = 0;
      else if (m_press[i]) m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
      m_press[i] = c_old && !m_prev[i];
      m_rel[i]   = !c_old && m_prev[i];
      m_prev[i]  = c_old;
      m_long[i]  = 0;
      if (!c_old) m_hold[i] = 0;
      else if (tick && m_hold[i] < LP) begin
        m_hold[i]++;
        if (m_hold[i] == LP) m_long[i] = 1;
      end
      if (tick) begin
        if (m_s2[i] != c_old) begin
          m_run[i]++;
          if (m_run[i] == WIN) begin
            m_clean[i] = !c_old;
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
    n_edges++;
  endtask

  task automatic compare_all();
    logic [N-1:0]    e_clean, e_press, e_rel, e_long;
    logic [N*CW-1:0] e_cnt;
    for (int i = 0; i < N; i++) begin
      e_clean[i] = m_clean[i];
      e_press[i] = m_press[i];
      e_rel[i]   = m_rel[i];
      e_long[i]  = m_long[i];
      e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
    end
    chk("btn_clean", 32'(btn_clean), 32'(e_clean));
    chk("press_pulse", 32'(press_pulse), 32'(e_press));
    chk("release_pulse", 32'(release_pulse), 32'(e_rel));
    chk("long_press", 32'(long_press), 32'(e_long));
    chk("press_count", 32'(press_count), 32'(e_cnt));
  endtask

  task automatic step(input int k);
    for (int c = 0; c < k; c++) begin
      count_clear = (clear_on_press & exp_press()) | manual_clear;
      @(posedge clk_100mhz);
      if (rst) model_reset();
      else     model_edge(btn_raw, count_clear);
      #1;
      cyc++;
      compare_all();
      for (int i = 0; i < N; i++) begin
        if (press_pulse[i])   press_seen[i]++;
        if (release_pulse[i]) release_seen[i]++;
        if (long_press[i])    begin long_seen[i]++; long_at[i] = cyc; end
        if (press_pulse[i])   rise_at[i] = cyc - 1;
      end
    end
  endtask

  task automatic wait_level(input int ch, input logic level, input int budget, output int lat);
    lat = 0;
    while (btn_clean[ch] !== level && lat < budget) begin
      step(1);
      lat++;
    end
    chk($sformatf("clean%0d_reaches_%0b", ch, level), 32'(btn_clean[ch]), 32'(level));
  endtask

  function automatic int dut_cnt(input int i);
    return int'(press_count[i*CW +: CW]);
  endfunction

  int lat, p0, r0, l0, p1, p3;

  initial begin
    model_reset();
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      press_seen[i] = 0; release_seen[i] = 0; long_seen[i] = 0;
      rise_at[i] = 0; long_at[i] = 0;
    end
    repeat (2) @(posedge clk_100mhz);
    #1;
    chk("reset_clean", 32'(btn_clean), 0);
    chk("reset_count", 32'(press_count), 0);
    chk("reset_pulses", 32'({press_pulse, release_pulse, long_press}), 0);
    rst = 1'b0;

    // Clean press on ch0, random phase relative to the tick.
    step($urandom_range(0, 9));
    btn_raw[0] = 1'b1;
    wait_level(0, 1'b1, 400, lat);
    chk("t1_rise_window", 32'(lat >= 150 && lat <= 175), 1);
    step(300 - lat);
    btn_raw[0] = 1'b0;
    wait_level(0, 1'b0, 400, lat);
    step(5);
    chk("t1_presses", 32'(press_seen[0]), 1);
    chk("t1_releases", 32'(release_seen[0]), 1);
    chk("t1_count", 32'(dut_cnt(0)), 1);

    // Bouncy press and release on ch0.
    for (int b = 0; b < 8; b++) begin
      btn_raw[0] = 1'b1; step($urandom_range(2, 8));
      btn_raw[0] = 1'b0; step($urandom_range(1, 5));
    end
    btn_raw[0] = 1'b1; step(500);
    for (int b = 0; b < 4; b++) begin
      btn_raw[0] = 1'b0; step($urandom_range(1, 5));
      btn_raw[0] = 1'b1; step($urandom_range(2, 8));
    end
    btn_raw[0] = 1'b0; step(300);
    chk("t2_presses", 32'(press_seen[0]), 2);
    chk("t2_releases", 32'(release_seen[0]), 2);
    chk("t2_count", 32'(dut_cnt(0)), 2);

    // Glitch and too-short pulses on ch1.
    btn_raw[1] = 1'b1; step(20);
    btn_raw[1] = 1'b0; step(50);
    for (int b = 0; b < 5; b++) begin
      btn_raw[1] = 1'b1; step(100);
      btn_raw[1] = 1'b0; step(100);
    end
    chk("t3_clean", 32'(btn_clean[1]), 0);
    chk("t3_presses", 32'(press_seen[1] + release_seen[1]), 0);
    chk("t3_count", 32'(dut_cnt(1)), 0);

    // Long hold on ch2 fires once; a shorter hold does not.
    btn_raw[2] = 1'b1; step(800);
    btn_raw[2] = 1'b0; step(300);
    chk("t4_long_once", 32'(long_seen[2]), 1);
    chk("t4_long_delay", 32'(long_at[2] - rise_at[2] >= 630 && long_at[2] - rise_at[2] <= 650), 1);
    btn_raw[2] = 1'b1; step(500);
    btn_raw[2] = 1'b0; step(300);
    chk("t4_no_long", 32'(long_seen[2]), 1);
    chk("t4_presses", 32'(press_seen[2]), 2);

    // Simultaneous presses; ch1 cleared in the same cycle as its press pulse.
    p1 = press_seen[1]; p3 = press_seen[3];
    clear_on_press = 4'b0010;
    btn_raw[1] = 1'b1; btn_raw[3] = 1'b1; step(300);
    btn_raw[1] = 1'b0; btn_raw[3] = 1'b0; step(300);
    clear_on_press = '0;
    chk("t5_press1", 32'(press_seen[1] - p1), 1);
    chk("t5_press3", 32'(press_seen[3] - p3), 1);
    chk("t5_count1_cleared", 32'(dut_cnt(1)), 0);
    chk("t5_count3", 32'(dut_cnt(3)), 1);

    // Counter wrap on ch0 (3-bit counter).
    manual_clear = 4'b0001; step(1); manual_clear = '0; step(1);
    chk("t5_manual_clear", 32'(dut_cnt(0)), 0);
    p0 = press_seen[0];
    for (int k = 1; k <= 8; k++) begin
      btn_raw[0] = 1'b1; step(200);
      btn_raw[0] = 1'b0; step(200);
      chk($sformatf("t5_wrap_%0d", k), 32'(dut_cnt(0)), 32'(k % 8));
    end
    chk("t5_wrap_presses", 32'(press_seen[0] - p0), 8);

    // Asynchronous reset in the middle of a ch0 press while ch3 is held high.
    btn_raw[3] = 1'b1; step(250);
    btn_raw[0] = 1'b1; step(80);
    chk("t6_pre_clean3", 32'(btn_clean[3]), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_clean", 32'(btn_clean), 0);
    chk("t6_async_count", 32'(press_count), 0);
    chk("t6_async_pulses", 32'({press_pulse, release_pulse, long_press}), 0);
    model_reset();
    step(20);
    rst = 1'b0;
    p0 = press_seen[0];
    wait_level(0, 1'b1, 400, lat);
    chk("t6_rise_after_reset", 32'(lat >= 160 && lat <= 175), 1);
    step(100);
    btn_raw = '0; step(300);
    chk("t6_count0", 32'(dut_cnt(0)), 1);
    chk("t6_count3", 32'(dut_cnt(3)), 1);
    chk("t6_press", 32'(press_seen[0] - p0), 1);

    // Randomized segments on all channels with occasional clears.
    for (int s = 0; s < 40; s++) begin
      btn_raw = N'($urandom);
      manual_clear = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step(1);
      manual_clear = '0;
      step($urandom_range(5, 400));
    end
    btn_raw = '0;
    step(400);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
